// File: rtl/display_7seg_scan.sv
// ============================================================================
// display_7seg_scan: N-digit common-anode 7-segment scanner, PWM brightness,
// frame snapshot. Optional blink feature: define DISP_BLINK_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module display_7seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [4*NUM_DIGITS-1:0]   din,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic                      hex_mode,
  input  logic                      lz_en,
  input  logic [3:0]                bright,
  input  logic [NUM_DIGITS-1:0]     blink,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int TW = CW + 1;
  localparam logic [CW-1:0] c_CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] c_SEL_MAX = SW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] c_UNIT    = TW'(SCAN_DIV / 16);

  logic [CW-1:0]           r_cnt;
  logic [SW-1:0]           r_sel;
  logic [4*NUM_DIGITS-1:0] r_din;
  logic [NUM_DIGITS-1:0]   r_dp, r_blank;
  logic                    r_hex, r_lz;
  logic [3:0]              r_bright;
  logic [6:0]              r_seg;
  logic                    r_dpo, r_fs;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_take;
  logic [4*NUM_DIGITS-1:0] w_s_din;
  logic [NUM_DIGITS-1:0]   w_s_dp, w_s_blank;
  logic                    w_s_hex, w_s_lz;
  logic [3:0]              w_s_bright;
  logic [3:0]              w_code;
  logic [6:0]              w_pat;
  logic                    w_zrun, w_lz_sup, w_blanked, w_on, w_bdark;
  logic [4:0]              w_b1;
  logic [TW-1:0]           w_thr;
  logic [6:0]              w_seg_n;
  logic                    w_dp_n;
  logic [NUM_DIGITS-1:0]   w_an_n;

  assign w_take = (r_cnt == '0) && (r_sel == '0);

  // The snapshot cycle decodes straight from the inputs so the first slot of
  // every frame already shows the new frame's data.
  assign w_s_din    = w_take ? din      : r_din;
  assign w_s_dp     = w_take ? dp_in    : r_dp;
  assign w_s_blank  = w_take ? blank    : r_blank;
  assign w_s_hex    = w_take ? hex_mode : r_hex;
  assign w_s_lz     = w_take ? lz_en    : r_lz;
  assign w_s_bright = w_take ? bright   : r_bright;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cnt <= '0;
      r_sel <= '0;
    end else if (r_cnt == c_CNT_MAX) begin
      r_cnt <= '0;
      r_sel <= (r_sel == c_SEL_MAX) ? '0 : r_sel + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_din    <= '0;
      r_dp     <= '0;
      r_blank  <= '0;
      r_hex    <= 1'b0;
      r_lz     <= 1'b0;
      r_bright <= '0;
    end else if (w_take) begin
      r_din    <= din;
      r_dp     <= dp_in;
      r_blank  <= blank;
      r_hex    <= hex_mode;
      r_lz     <= lz_en;
      r_bright <= bright;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] c_BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0]         r_bcnt;
  logic                  r_phase;
  logic [NUM_DIGITS-1:0] r_blink;
  logic [NUM_DIGITS-1:0] w_s_blink;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      r_blink <= '0;
    end else begin
      if (r_bcnt == c_BLINK_MAX) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
      if (w_take) r_blink <= blink;
    end
  end

  assign w_s_blink = w_take ? blink : r_blink;
  assign w_bdark   = r_phase & w_s_blink[r_sel];
`else
  localparam logic [31:0] c_unused_bdiv = 32'(BLINK_DIV);
  logic w_unused_blink;
  assign w_unused_blink = ^blink;
  assign w_bdark        = 1'b0;
`endif

  assign w_code = w_s_din[{r_sel, 2'b00} +: 4];

  always_comb begin
    w_pat = 7'h7F;
    case (w_code)
      4'h0: w_pat = 7'h40;
      4'h1: w_pat = 7'h79;
      4'h2: w_pat = 7'h24;
      4'h3: w_pat = 7'h30;
      4'h4: w_pat = 7'h19;
      4'h5: w_pat = 7'h12;
      4'h6: w_pat = 7'h02;
      4'h7: w_pat = 7'h78;
      4'h8: w_pat = 7'h00;
      4'h9: w_pat = 7'h10;
      4'hA: w_pat = 7'h08;
      4'hB: w_pat = 7'h03;
      4'hC: w_pat = 7'h46;
      4'hD: w_pat = 7'h21;
      4'hE: w_pat = 7'h06;
      4'hF: w_pat = 7'h0E;
      default: w_pat = 7'h7F;
    endcase
    if (w_code > 4'd9 && !w_s_hex) w_pat = 7'h7F;
  end

  // Zero-run from digit 0 up to the selected digit; the last digit always shows.
  always_comb begin
    w_zrun   = 1'b1;
    w_lz_sup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_zrun = w_zrun & (w_s_din[4*i +: 4] == 4'd0);
      if (i == int'(r_sel) && i != NUM_DIGITS - 1) w_lz_sup = w_zrun;
    end
    w_lz_sup = w_lz_sup & w_s_lz;
  end

  assign w_b1      = {1'b0, w_s_bright} + 5'd1;
  assign w_thr     = {{(TW-5){1'b0}}, w_b1} * c_UNIT;
  assign w_on      = {1'b0, r_cnt} < w_thr;
  assign w_blanked = w_s_blank[r_sel] | w_lz_sup;

  always_comb begin
    w_an_n  = '1;
    w_seg_n = 7'h7F;
    w_dp_n  = 1'b1;
    if (w_on && !w_bdark) begin
      w_an_n[r_sel] = 1'b0;
      w_seg_n       = w_blanked ? 7'h7F : w_pat;
      w_dp_n        = ~(w_s_dp[r_sel] & ~w_s_blank[r_sel]);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_seg <= 7'h7F;
      r_dpo <= 1'b1;
      r_an  <= '1;
      r_fs  <= 1'b0;
    end else begin
      r_seg <= w_seg_n;
      r_dpo <= w_dp_n;
      r_an  <= w_an_n;
      r_fs  <= w_take;
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dpo;
  assign an          = r_an;
  assign frame_start = r_fs;

endmodule

`default_nettype wire

// File: tb/tb_display_7seg_scan.sv
// ============================================================================
// tb_display_7seg_scan: table vectors, directed corner sequences and random
// stimulus checked against a frame-level reference model.        Rev 1.0
// ============================================================================
`default_nettype none

module tb_display_7seg_scan;

  localparam int N  = 4;
  localparam int SD = 32;
  localparam int FR = N * SD;
`ifdef DISP_BLINK_EN
  localparam int BD = 64;
`else
  localparam int BD = 25000000;
`endif

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [15:0]     din = 16'hFFFF;
  logic [3:0]      dp_in = 4'hF, blank = 4'h0, blink = 4'h0, bright = 4'hF;
  logic            hex_mode = 1'b1, lz_en = 1'b0;
  logic [6:0]      seg;
  logic            dp, frame_start;
  logic [3:0]      an;

  always #5 CLK = ~CLK;

  display_7seg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .CLK(CLK), .RST_N(RST_N), .din(din), .dp_in(dp_in), .blank(blank),
    .hex_mode(hex_mode), .lz_en(lz_en), .bright(bright), .blink(blink),
    .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );

  int vectors = 0, errors = 0;
  int k = 0;
  int last_sel = 0, last_cnt = 0;

  // Frame snapshot held by the model
  logic [15:0] m_din;
  logic [3:0]  m_dp, m_blank, m_br;
  logic        m_hex, m_lz;
`ifdef DISP_BLINK_EN
  logic [3:0]  m_blink;
`endif

  // Segment strings in a..g order, '0' = lit
  string pat_s [16] = '{"0000001", "1001111", "0010010", "0000110",
                        "1001100", "0100100", "0100000", "0001111",
                        "0000000", "0000100", "0001000", "1100000",
                        "0110001", "1000010", "0110000", "0111000"};

  function automatic logic [6:0] pat(input string s);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = (s.getc(i) == 8'h31);
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] code, input logic hx);
    if (code > 4'd9 && !hx) return 7'h7F;
    return pat(pat_s[code]);
  endfunction

  function automatic logic [15:0] dg(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%h expected=%h", name, k, got, exp);
    end
  endtask

  // One clock: capture snapshot at frame start, then compare all outputs
  task automatic step();
    logic [3:0] e_an, code;
    logic [6:0] e_seg;
    logic       e_dp, e_fs, on, dark, sup;
    int         sel, cnt;
    if (k % FR == 0) begin
      m_din = din; m_dp = dp_in; m_blank = blank;
      m_hex = hex_mode; m_lz = lz_en; m_br = bright;
`ifdef DISP_BLINK_EN
      m_blink = blink;
`endif
    end
    @(posedge CLK); #1;
    sel  = (k / SD) % N;
    cnt  = k % SD;
    code = m_din[4*sel +: 4];
    sup  = m_lz && (sel != N - 1);
    for (int j = 0; j <= sel; j++) if (m_din[4*j +: 4] != 4'd0) sup = 1'b0;
    on   = cnt < (int'(m_br) + 1) * (SD / 16);
    dark = 1'b0;
`ifdef DISP_BLINK_EN
    dark = ((k / BD) % 2 == 1) && m_blink[sel];
`endif
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = (k % FR == 0);
    if (on && !dark) begin
      e_an[sel] = 1'b0;
      if (!(m_blank[sel] || sup)) e_seg = glyph(code, m_hex);
      e_dp = !(m_dp[sel] && !m_blank[sel]);
    end
    check("scan", {3'b0, an, seg, dp, frame_start}, {3'b0, e_an, e_seg, e_dp, e_fs});
    last_sel = sel;
    last_cnt = cnt;
    k++;
  endtask

  task automatic rand_inputs();
    for (int j = 0; j < N; j++)
      din[4*j +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
    dp_in    = 4'($urandom);
    blank    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
    hex_mode = 1'($urandom_range(0, 1));
    lz_en    = 1'($urandom_range(0, 1));
    bright   = 4'($urandom);
    blink    = 4'($urandom);
  endtask

  task automatic reset_cycles(input int n, input string name);
    RST_N = 1'b0;
    repeat (n) begin
      @(posedge CLK); #1;
      check(name, {3'b0, an, seg, dp, frame_start}, {3'b0, 4'hF, 7'h7F, 1'b1, 1'b0});
    end
    RST_N = 1'b1;
    k = 0;
  endtask

  typedef struct packed {
    logic [15:0]      din;
    logic [3:0]       dpi;
    logic [3:0]       blk;
    logic             hx;
    logic             lz;
    logic [3:0][6:0]  es;
    logic [3:0]       edp;
  } vec_t;

  vec_t tbl [7];

  task automatic fill(input int i, input logic [15:0] d, input logic [3:0] dpi,
                      input logic [3:0] blk, input logic hx, input logic lz,
                      input string s0, input string s1, input string s2,
                      input string s3, input logic [3:0] edp);
    tbl[i].din = d;  tbl[i].dpi = dpi; tbl[i].blk = blk;
    tbl[i].hx  = hx; tbl[i].lz  = lz;  tbl[i].edp = edp;
    tbl[i].es[0] = pat(s0); tbl[i].es[1] = pat(s1);
    tbl[i].es[2] = pat(s2); tbl[i].es[3] = pat(s3);
  endtask

  initial begin
    int nfs, lo0, lo2, lo3;
    logic [3:0] ea;
    string bl;
    bl = "1111111";
    fill(0, dg(1, 2, 3, 4), 4'b0000, 4'b0000, 1'b0, 1'b0,
         "1001111", "0010010", "0000110", "1001100", 4'b0000);
    fill(1, dg(10, 11, 12, 13), 4'b0000, 4'b0000, 1'b1, 1'b0,
         "0001000", "1100000", "0110001", "1000010", 4'b0000);
    fill(2, dg(10, 11, 12, 13), 4'b0000, 4'b0000, 1'b0, 1'b0, bl, bl, bl, bl, 4'b0000);
    fill(3, dg(0, 0, 0, 5), 4'b0000, 4'b0000, 1'b0, 1'b1, bl, bl, bl, "0100100", 4'b0000);
    fill(4, dg(0, 0, 0, 0), 4'b0010, 4'b0000, 1'b0, 1'b1, bl, bl, bl, "0000001", 4'b0010);
    fill(5, dg(7, 8, 9, 14), 4'b1111, 4'b0100, 1'b1, 1'b0,
         "0001111", "0000000", bl, "0110000", 4'b1011);
    fill(6, dg(0, 3, 0, 0), 4'b0001, 4'b0000, 1'b0, 1'b1,
         bl, "0000110", "0000001", "0000001", 4'b0001);

    reset_cycles(4, "reset");

    // Table-driven frames at full brightness
    bright = 4'hF; blink = 4'h0;
    for (int t = 0; t < 7; t++) begin
      din = tbl[t].din; dp_in = tbl[t].dpi; blank = tbl[t].blk;
      hex_mode = tbl[t].hx; lz_en = tbl[t].lz;
      repeat (FR) begin
        step();
        if (last_cnt == 0) begin
          ea = 4'hF; ea[last_sel] = 1'b0;
          check("tbl_an",  {12'b0, an}, {12'b0, ea});
          check("tbl_seg", {9'b0, seg}, {9'b0, tbl[t].es[last_sel]});
          check("tbl_dp",  {15'b0, dp}, {15'b0, ~tbl[t].edp[last_sel]});
        end
      end
    end

    // Mid-frame input change must wait for the next frame
    din = dg(1, 1, 1, 1); dp_in = 4'h0; blank = 4'h0; lz_en = 1'b0; hex_mode = 1'b0;
    nfs = 0;
    for (int c = 0; c < 2 * FR; c++) begin
      step();
      if (frame_start) nfs++;
      if (c == 2 * SD + 5) din = dg(2, 2, 2, 2);
      if (c == 3 * SD) check("coh_old", {9'b0, seg}, {9'b0, pat("1001111")});
      if (c == FR)     check("coh_new", {9'b0, seg}, {9'b0, pat("0010010")});
    end
    check("fs_count", 16'(nfs), 16'd2);

    // PWM duty per slot
    bright = 4'd0; lo0 = 0;
    repeat (FR) begin step(); if (an[0] == 1'b0) lo0++; end
    check("pwm_b0", 16'(lo0), 16'd2);
    bright = 4'd7; lo0 = 0;
    repeat (FR) begin step(); if (an[0] == 1'b0) lo0++; end
    check("pwm_b7", 16'(lo0), 16'd16);

    // Random stimulus with mid-frame changes
    rand_inputs();
    repeat (8 * FR) begin
      step();
      if ($urandom_range(0, 15) == 0) rand_inputs();
    end

    // Reset mid-frame, then restart from digit 0
    repeat (50) step();
    reset_cycles(3, "reset_mid");
    din = dg(1, 2, 3, 4); dp_in = 4'h0; blank = 4'h0; lz_en = 1'b0;
    bright = 4'hF; blink = 4'b1000;
    lo2 = 0; lo3 = 0;
    repeat (FR) begin
      step();
      if (an[2] == 1'b0) lo2++;
      if (an[3] == 1'b0) lo3++;
    end
`ifdef DISP_BLINK_EN
    check("blink_d3", 16'(lo3), 16'd0);
`else
    check("blink_d3", 16'(lo3), 16'd32);
`endif
    check("blink_d2", 16'(lo2), 16'd32);

    rand_inputs();
    repeat (2 * FR) begin
      step();
      if ($urandom_range(0, 31) == 0) rand_inputs();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
